// File: rtl/i2s_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer_if
// Sample-pair handshake between the upstream audio FIFO (master) and the
// I2S transmitter (slave).
//   in_left  [MAX_WIDTH] left sample, right-justified
//   in_right [MAX_WIDTH] right sample, right-justified
//   in_valid             pair valid (master -> slave)
//   in_ready             holding register empty (slave -> master)
// A pair transfers on a clk edge where in_valid & in_ready.
// ---------------------------------------------------------------------------
interface i2s_tx_serializer_if #(
  parameter int MAX_WIDTH = 32
);
  logic [MAX_WIDTH-1:0] in_left;
  logic [MAX_WIDTH-1:0] in_right;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_left, output in_right, output in_valid, input in_ready);
  modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
// Stereo I2S / left-justified transmitter. A left/right pair is accepted into
// a one-frame holding register, copied to a shadow register at each frame
// boundary and shifted out MSB-first on sd, with sck and ws generated here.
// Ports:
//   clk, rst_n    system clock (rising edge), async active-low reset
//   enable        1 = stream, 0 = stop at the end of the current frame
//   mode          0 = Philips I2S, 1 = left-justified (latched per frame)
//   sample_size   0:8 1:16 2:24 3:32 bits (latched per frame)
//   in_if         sample-pair handshake (slave side)
//   sck, ws, sd   serial bit clock, word select (1 = right), serial data
//   frame_start   1-clk pulse at each frame boundary
//   underrun      1-clk pulse when a boundary finds the holding register empty
// ---------------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int MAX_WIDTH  = 32,
  parameter int SLOT_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                mode,
  input  logic [1:0]          sample_size,
  i2s_tx_serializer_if.slave  in_if,
  output logic                sck,
  output logic                ws,
  output logic                sd,
  output logic                frame_start,
  output logic                underrun
);

  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 sck_q, sck_d;
  logic                 ws_q, ws_d;
  logic                 sd_q, sd_d;
  logic                 frame_start_q, frame_start_d;
  logic                 underrun_q, underrun_d;
  logic                 hold_full_q, hold_full_d;
  logic [MAX_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [MAX_WIDTH-1:0] shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
  logic [1:0]           size_q, size_d;
  logic                 mode_q, mode_d;
  logic                 prev_lsb_q, prev_lsb_d;
  logic                 boundary, from_idle, accept;

  // Effective sample size: nominal size clamped to the port and slot widths.
  function automatic int eff_n(input logic [1:0] s);
    int n;
    n = (int'(s) + 1) * 8;
    if (n > MAX_WIDTH)  n = MAX_WIDTH;
    if (n > SLOT_WIDTH) n = SLOT_WIDTH;
    return n;
  endfunction

  // Serial data bit for a given frame position. In I2S mode a full-slot
  // sample spills its LSB into p=0 of the following slot; for the left slot
  // that LSB belongs to the previous frame's right sample (prev_lsb).
  function automatic logic sd_bit(input logic [CNT_W-1:0]     cnt,
                                  input logic [MAX_WIDTH-1:0] l,
                                  input logic [MAX_WIDTH-1:0] r,
                                  input int                   n,
                                  input logic                 lj,
                                  input logic                 prev_lsb);
    int                   p;
    int                   idx;
    logic                 ch;
    logic                 b;
    logic [MAX_WIDTH-1:0] w;
    p   = int'(cnt) % SLOT_WIDTH;
    ch  = (int'(cnt) >= SLOT_WIDTH);
    w   = ch ? r : l;
    idx = -1;
    b   = 1'b0;
    if (lj) begin
      if (p < n) idx = n - 1 - p;
    end else if (p >= 1 && p <= n) begin
      idx = n - p;
    end else if (p == 0 && n == SLOT_WIDTH) begin
      b = ch ? l[0] : prev_lsb;
    end
    if (idx >= 0) begin
      w = w >> idx;
      b = w[0];
    end
    return b;
  endfunction

  assign accept         = in_if.in_valid & ~hold_full_q;
  assign in_if.in_ready = ~hold_full_q;

  // Timing FSM: divider, sck, bit counter and frame boundaries.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    div_d     = div_q;
    sck_d     = sck_q;
    bit_cnt_d = bit_cnt_q;
    boundary  = 1'b0;
    from_idle = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d     = '0;
        sck_d     = 1'b0;
        bit_cnt_d = '0;
        if (enable) begin
          state_d   = S_RUN;
          boundary  = 1'b1;
          from_idle = 1'b1;
        end
      end
      default: begin
        if (state_q == S_RUN && !enable)        state_d = S_DRAIN;
        else if (state_q == S_DRAIN && enable)  state_d = S_RUN;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_d = '0;
              // A drain re-enabled by the last bit still rolls into a new frame.
              if (state_q == S_RUN || enable) boundary = 1'b1;
              else                            state_d  = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase
  end

  // Datapath: holding/shadow registers and registered serial outputs.
  always_comb begin
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    shadow_l_d    = shadow_l_q;
    shadow_r_d    = shadow_r_q;
    size_d        = size_q;
    mode_d        = mode_q;
    prev_lsb_d    = prev_lsb_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    if (boundary) begin
      frame_start_d = 1'b1;
      size_d        = sample_size;
      mode_d        = mode;
      prev_lsb_d    = (!from_idle && !mode_q && eff_n(size_q) == SLOT_WIDTH) ? shadow_r_q[0] : 1'b0;
      if (hold_full_q) begin
        shadow_l_d  = hold_l_q;
        shadow_r_d  = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        shadow_l_d  = '0;
        shadow_r_d  = '0;
        underrun_d  = 1'b1;
      end
    end
    // Accept only happens while empty, so a same-clk load has already taken the old contents.
    if (accept) begin
      hold_l_d    = in_if.in_left;
      hold_r_d    = in_if.in_right;
      hold_full_d = 1'b1;
    end
    // Next-state inputs only move on sck falling edges or frame entry, so ws/sd do too.
    ws_d = (state_d != S_IDLE) && (int'(bit_cnt_d) >= SLOT_WIDTH);
    sd_d = (state_d != S_IDLE) &&
           sd_bit(bit_cnt_d, shadow_l_d, shadow_r_d, eff_n(size_d), mode_d, prev_lsb_d);
  end

  // NOTE: sample data registers are reset too, so an aborted frame leaves no stale audio to replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      bit_cnt_q     <= '0;
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
      size_q        <= '0;
      mode_q        <= 1'b0;
      prev_lsb_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      div_q         <= div_d;
      bit_cnt_q     <= bit_cnt_d;
      sck_q         <= sck_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
      size_q        <= size_d;
      mode_q        <= mode_d;
      prev_lsb_q    <= prev_lsb_d;
    end
  end

  assign sck         = sck_q;
  assign ws          = ws_q;
  assign sd          = sd_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
